// File: rtl/olink_tx_framer.sv
// Optical-link TX framer: 32-bit payload stream in, 16-bit/cycle GTX words out.
// Frames are wrapped in SOF/trailer/EOF slots, gaps are IDLE, and every COMMA_PERIOD-th slot is a comma.
module olink_tx_framer #(
    parameter int COMMA_PERIOD = 64,
    parameter int MAX_WORDS    = 4095
) (
    input  logic        clk_link,
    input  logic        reset,
    input  logic [31:0] in_d,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] tx_d,
    output logic [1:0]  tx_k,
    output logic [31:0] frames_sent,
    output logic [31:0] words_dropped,
    output logic [31:0] commas_sent
);

    localparam int SLOT_W = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;

    localparam logic [31:0] W_COMMA = 32'h0000_00BC;
    localparam logic [31:0] W_IDLE  = 32'hF7F7_F7F7;
    localparam logic [31:0] W_SOF   = 32'hFBFB_FBFB;
    localparam logic [31:0] W_EOF   = 32'hFDFD_FDFD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_PAYLOAD,
        ST_TRAILER,
        ST_EOF
    } state_t;

    state_t             state_q, state_d;
    logic               half_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [11:0]        count_q, count_d;
    logic [15:0]        csum_q, csum_d;
    logic [1:0]         status_q, status_d;
    logic [31:0]        frames_q, frames_d;
    logic [31:0]        dropped_q, dropped_d;
    logic [31:0]        commas_q, commas_d;
    logic [31:0]        slot_word_d;
    logic [3:0]         slot_k_d;
    logic [15:0]        tx_d_q, hi_d_q;
    logic [1:0]         tx_k_q, hi_k_q;
    logic               comma_slot;
    logic               decide;
    logic               accept;

    function automatic logic [15:0] fold16(input logic [31:0] w);
        return w[31:16] ^ w[15:0];
    endfunction

    assign comma_slot = (slot_q == '0);
    assign decide     = !half_q && !comma_slot;

    // Ready never depends on in_valid; the first payload slot takes the held sop word.
    always_comb begin
        in_ready = 1'b0;
        if (decide) begin
            case (state_q)
                ST_IDLE:    in_ready = !in_sop;
                ST_PAYLOAD: in_ready = (count_q == 12'd0) || !in_sop;
                default:    in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        csum_d      = csum_q;
        status_d    = status_q;
        frames_d    = frames_q;
        dropped_d   = dropped_q;
        commas_d    = commas_q;
        slot_word_d = W_IDLE;
        slot_k_d    = 4'b1111;

        if (!half_q && comma_slot) begin
            slot_word_d = W_COMMA;
            slot_k_d    = 4'b0001;
            commas_d    = commas_q + 32'd1;
        end else if (decide) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_sop) begin
                        slot_word_d = W_SOF;
                        state_d     = ST_PAYLOAD;
                    end else if (accept) begin
                        dropped_d = dropped_q + 32'd1;
                    end
                end
                ST_SOF: begin
                    slot_word_d = W_SOF;
                    state_d     = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        slot_word_d = in_d;
                        slot_k_d    = 4'b0000;
                        count_d     = count_q + 12'd1;
                        csum_d      = csum_q ^ fold16(in_d);
                        if (in_eop) begin
                            state_d = ST_TRAILER;
                        end else if (count_d == 12'(MAX_WORDS)) begin
                            status_d[0] = 1'b1;
                            state_d     = ST_TRAILER;
                        end
                    end else if (in_valid) begin
                        // A new sop while a frame is open aborts the current one.
                        status_d[1] = 1'b1;
                        state_d     = ST_TRAILER;
                    end
                end
                ST_TRAILER: begin
                    slot_word_d = {2'b00, status_q, count_q, csum_q};
                    slot_k_d    = 4'b0000;
                    state_d     = ST_EOF;
                end
                ST_EOF: begin
                    slot_word_d = W_EOF;
                    frames_d    = frames_q + 32'd1;
                    count_d     = '0;
                    csum_d      = '0;
                    status_d    = '0;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_link) begin
        if (reset) begin
            half_q    <= 1'b0;
            slot_q    <= '0;
            state_q   <= ST_IDLE;
            count_q   <= '0;
            csum_q    <= '0;
            status_q  <= '0;
            frames_q  <= '0;
            dropped_q <= '0;
            commas_q  <= '0;
            tx_d_q    <= 16'hF7F7;
            tx_k_q    <= 2'b11;
        end else begin
            half_q <= !half_q;
            if (half_q) begin
                slot_q <= (slot_q == SLOT_W'(COMMA_PERIOD - 1)) ? '0 : slot_q + 1'b1;
            end
            state_q   <= state_d;
            count_q   <= count_d;
            csum_q    <= csum_d;
            status_q  <= status_d;
            frames_q  <= frames_d;
            dropped_q <= dropped_d;
            commas_q  <= commas_d;
            if (!half_q) begin
                tx_d_q <= slot_word_d[15:0];
                tx_k_q <= slot_k_d[1:0];
            end else begin
                tx_d_q <= hi_d_q;
                tx_k_q <= hi_k_q;
            end
        end
    end

    // High half waits one cycle behind the low half.
    always_ff @(posedge clk_link) begin
        if (!half_q) begin
            hi_d_q <= slot_word_d[31:16];
            hi_k_q <= slot_k_d[3:2];
        end
    end

    assign tx_d          = tx_d_q;
    assign tx_k          = tx_k_q;
    assign frames_sent   = frames_q;
    assign words_dropped = dropped_q;
    assign commas_sent   = commas_q;

endmodule

// File: doc/olink_tx_framer.md
# olink_tx_framer

Transmit framer feeding the optical-link GTX TX datapath (`tx_d`/`tx_k`, 16 bits per `clk_link` cycle). It accepts 32-bit payload words through a valid/ready stream with start/end markers and serialises them low half first. It wraps each frame in SOF, trailer and EOF words, fills gaps with IDLE and inserts periodic comma words. The output is formatted so the link receiver's 16→32 reassembly (comma-aligned pairing, all-K or all-data words) always produces aligned words.

## Interface
- `COMMA_PERIOD`, 64: word slots per comma cycle, including the comma slot; legal range 4–1024.
- `MAX_WORDS`, 4095: maximum payload words per frame; legal range 1–4095.
- `clk_link` in 1: link user clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `in_d` in 32: payload word.
- `in_sop` in 1: `in_d` is the first word of a frame.
- `in_eop` in 1: `in_d` is the last word of a frame; may coincide with `in_sop`.
- `in_valid` in 1: input word present.
- `in_ready` out 1: combinational; a word is accepted on `in_valid && in_ready`.
- `tx_d` out 16: to GTX `txdata`; registered.
- `tx_k` out 2: to GTX `txcharisk`; registered.
- `frames_sent` out 32: count of EOF words emitted.
- `words_dropped` out 32: count of words discarded outside a frame.
- `commas_sent` out 32: count of comma slots emitted.

## Operation
- Each word slot is 2 cycles. `half`=0 is the decision cycle; `half`=1 follows. The low half of the slot word goes out on the cycle after `half`=0; the high half goes out the cycle after that.
- Slot words, listed as {high half, low half} with k:
  - COMMA: 16'h0000 k=00, then 16'h00BC k=01.
  - IDLE: F7F7/F7F7, k=11 on both halves.
  - SOF: FBFB/FBFB, k=11.
  - EOF: FDFD/FDFD, k=11.
  - DATA and TRAILER: k=00.
- Comma insertion: the slot counter runs 0..`COMMA_PERIOD`-1 and wraps. Slot 0 is always COMMA, overriding every state. The FSM holds its state through the comma slot, and `in_ready`=0 in that slot.
- FSM states: IDLE, SOF, PAYLOAD, TRAILER, EOF. Evaluated only at `half`=0 of non-comma slots.
- IDLE:
  - With `in_valid && in_sop`: emit SOF and go to PAYLOAD. The word is not accepted.
  - With `in_valid && !in_sop`: accept and discard; `words_dropped`++. Emit IDLE.
  - Otherwise emit IDLE.
- PAYLOAD, with `in_ready`=1:
  - `in_valid && !in_sop`: accept and emit DATA; word count++; checksum ^= `in_d[31:16]`^`in_d[15:0]`.
  - The first PAYLOAD slot accepts the pending `in_sop` word as data.
  - `in_eop`, or word count reaching `MAX_WORDS`: go to TRAILER. Reaching `MAX_WORDS` without `in_eop` sets status bit0 (truncated).
  - `!in_valid`: emit IDLE and stay in PAYLOAD.
- `in_sop` arriving in PAYLOAD after the first word: not accepted (`in_ready`=0). Set status bit1 (aborted) and go to TRAILER. The new frame then starts from IDLE.
- TRAILER: emit {status[3:0], count[11:0], checksum[15:0]}; status[3:2]=0. Go to EOF.
- EOF: emit EOF; `frames_sent`++. Clear count, checksum and status; go to IDLE.
- Words remaining after a truncation carry no `in_sop`, so they are dropped in IDLE.
- `in_ready`=1 only at `half`=0, in a non-comma slot, in IDLE (for a non-sop word) or PAYLOAD (as above). It is 0 in all other cycles.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - `tx_d`=16'hF7F7, `tx_k`=2'b11.
  - `half`=0, slot counter=0 (first slot after reset is COMMA).
  - FSM=IDLE; count, checksum and status=0.
  - All three counters=0.
- Reset mid-frame: the frame is abandoned with no trailer or EOF. Output resumes with a COMMA slot.
- Latency: a word accepted in cycle N has its low half on `tx_d` in N+1 and its high half in N+2.
- Throughput: at most one payload word per 2 cycles. Frame overhead is 3 slots plus comma slots.
- A word held on `in_valid` while `in_ready`=0 must remain stable until accepted.

## Test plan
- Reset, no input: cycles 1–2 show COMMA (00BC/k01, 0000/k00), then IDLE F7F7/k11 in every cycle. Slot `COMMA_PERIOD` (cycle 128 with default) is COMMA again; `commas_sent`=2 after 130 cycles.
- Three-word frame A5A5_0001, A5A5_0002, A5A5_0003 (eop on the third): output is SOF, the three DATA words low half first, trailer {4'h0, 12'h003, 16'hA5A5^0001^A5A5^0002^A5A5^0003 = 16'hA5A5}, then EOF. `frames_sent`=1.
- Frame spanning slot 0: the comma appears mid-payload and the input stalls for exactly 2 cycles. Payload order and checksum are unchanged.
- `MAX_WORDS`=4 with a 6-word frame: trailer status=1 and count=4, then EOF. The 2 leftover words are dropped; `words_dropped`=2.
- `in_sop` on the third word: the trailer carries status=2 and count=2, followed by EOF, then SOF for the new frame whose first word is the held sop word.
- `in_valid` gaps mid-frame emit IDLE slots. `reset` asserted during PAYLOAD: the next output is COMMA and all counters read 0.
